// File: rtl/mips_bus_pkg.sv
// rtl/mips_bus_pkg.sv - shared types and helpers for the MIPS bus master
package mips_bus_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE  = 2'd0,
        SZ_HALF  = 2'd1,
        SZ_WORD  = 2'd2,
        SZ_DWORD = 2'd3
    } access_size_t;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_MISALIGN = 2'd1,
        ERR_TIMEOUT  = 2'd2
    } bus_err_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_ERR  = 2'd2
    } bus_state_t;

    // Unshifted byte-enable pattern for an access of the given size.
    function automatic logic [7:0] size_mask(input access_size_t sz);
        case (sz)
            SZ_BYTE: return 8'h01;
            SZ_HALF: return 8'h03;
            SZ_WORD: return 8'h0F;
            default: return 8'hFF;
        endcase
    endfunction

    // Natural alignment check; a dword on a 32-bit bus is always rejected.
    function automatic logic is_misaligned(input access_size_t sz,
                                           input logic [2:0] a,
                                           input logic dword_ok);
        case (sz)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return a[0];
            SZ_WORD: return |a[1:0];
            default: return !dword_ok || (|a);
        endcase
    endfunction

endpackage

// File: rtl/mips_bus_lane_steer.sv
// rtl/mips_bus_lane_steer.sv - byte-lane steering for stores and load extraction/extension
// Ports:
//   st_size/st_lane/st_wdata -> st_be/st_data : store byteenable and lane-shifted data
//   ld_size/ld_lane/ld_signed/ld_data -> ld_result : right-justified, extended load data
module mips_bus_lane_steer
    import mips_bus_pkg::*;
#(
    parameter int DATA_W = 32,
    localparam int BE_W = DATA_W / 8,
    localparam int LANE_W = $clog2(BE_W)
) (
    input  access_size_t      st_size,
    input  logic [LANE_W-1:0] st_lane,
    input  logic [DATA_W-1:0] st_wdata,
    output logic [BE_W-1:0]   st_be,
    output logic [DATA_W-1:0] st_data,
    input  access_size_t      ld_size,
    input  logic [LANE_W-1:0] ld_lane,
    input  logic              ld_signed,
    input  logic [DATA_W-1:0] ld_data,
    output logic [DATA_W-1:0] ld_result
);

    logic [BE_W-1:0]   base_be;
    logic [DATA_W-1:0] base_bits;
    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] ld_mask;
    logic              sign_bit;

    // Store side: bits above the access size are cleared before shifting so
    // unused lanes always carry zero.
    always_comb begin
        base_be = BE_W'(size_mask(st_size));
        base_bits = '0;
        for (int i = 0; i < BE_W; i++) begin
            base_bits[i*8 +: 8] = {8{base_be[i]}};
        end
        st_be   = base_be << st_lane;
        st_data = (st_wdata & base_bits) << {st_lane, 3'b000};
    end

    // Load side: bring the addressed lane down to bit 0, then mask and extend.
    always_comb begin
        shifted  = ld_data >> {ld_lane, 3'b000};
        ld_mask  = '1;
        sign_bit = 1'b0;
        case (ld_size)
            SZ_BYTE: begin
                ld_mask  = DATA_W'(8'hFF);
                sign_bit = shifted[7];
            end
            SZ_HALF: begin
                ld_mask  = DATA_W'(16'hFFFF);
                sign_bit = shifted[15];
            end
            SZ_WORD: begin
                ld_mask  = DATA_W'(32'hFFFF_FFFF);
                sign_bit = shifted[31];
            end
            default: begin
                ld_mask  = '1;
                sign_bit = 1'b0;
            end
        endcase
        ld_result = shifted & ld_mask;
        if (ld_signed && sign_bit) begin
            ld_result = ld_result | ~ld_mask;
        end
    end

endmodule

// File: rtl/mips_bus_master.sv
// rtl/mips_bus_master.sv - single-outstanding load/store engine from MIPS core to Avalon-style bus
// Ports:
//   clk, reset                      : clock, synchronous active-high reset
//   req_* / req_ready               : core request handshake (accepted in IDLE only)
//   resp_valid/resp_rdata/resp_err  : one-cycle completion with extended load data and status
//   address/read/write/waitrequest/
//   writedata/byteenable/readdata   : memory bus
module mips_bus_master
    import mips_bus_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 0,
    localparam int BE_W = DATA_W / 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic [1:0]        resp_err,
    output logic [ADDR_W-1:0] address,
    output logic              read,
    output logic              write,
    input  logic              waitrequest,
    output logic [DATA_W-1:0] writedata,
    output logic [BE_W-1:0]   byteenable,
    input  logic [DATA_W-1:0] readdata
);

    localparam int LANE_W = $clog2(BE_W);
    localparam int CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    bus_state_t state, state_d;

    logic              lat_write, lat_write_d;
    access_size_t      lat_size, lat_size_d;
    logic              lat_signed, lat_signed_d;
    logic [LANE_W-1:0] lat_lane, lat_lane_d;
    logic [CNT_W-1:0]  cnt, cnt_d;

    logic              read_d, write_d, resp_valid_d;
    logic [ADDR_W-1:0] address_d;
    logic [DATA_W-1:0] writedata_d, resp_rdata_d;
    logic [BE_W-1:0]   byteenable_d;
    logic [1:0]        resp_err_d;

    access_size_t      req_sz;
    logic [BE_W-1:0]   st_be;
    logic [DATA_W-1:0] st_data;
    logic [DATA_W-1:0] ld_result;

    assign req_sz    = access_size_t'(req_size);
    assign req_ready = (state == ST_IDLE);

    // Store lanes come from the live request (used only on the accept edge);
    // load extraction uses the request latched at accept time.
    mips_bus_lane_steer #(.DATA_W(DATA_W)) u_steer (
        .st_size   (req_sz),
        .st_lane   (req_addr[LANE_W-1:0]),
        .st_wdata  (req_wdata),
        .st_be     (st_be),
        .st_data   (st_data),
        .ld_size   (lat_size),
        .ld_lane   (lat_lane),
        .ld_signed (lat_signed),
        .ld_data   (readdata),
        .ld_result (ld_result)
    );

    always_comb begin
        state_d      = state;
        lat_write_d  = lat_write;
        lat_size_d   = lat_size;
        lat_signed_d = lat_signed;
        lat_lane_d   = lat_lane;
        cnt_d        = cnt;
        read_d       = read;
        write_d      = write;
        address_d    = address;
        writedata_d  = writedata;
        byteenable_d = byteenable;
        resp_valid_d = 1'b0;
        resp_rdata_d = resp_rdata;
        resp_err_d   = resp_err;

        case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    lat_write_d  = req_write;
                    lat_size_d   = req_sz;
                    lat_signed_d = req_signed;
                    lat_lane_d   = req_addr[LANE_W-1:0];
                    if (is_misaligned(req_sz, req_addr[2:0], DATA_W == 64)) begin
                        state_d = ST_ERR;
                    end else begin
                        state_d      = ST_BUS;
                        cnt_d        = '0;
                        read_d       = !req_write;
                        write_d      = req_write;
                        address_d    = {req_addr[ADDR_W-1:LANE_W], LANE_W'(0)};
                        byteenable_d = st_be;
                        writedata_d  = st_data;
                    end
                end
            end
            ST_BUS: begin
                // Completion is checked first so a zero waitrequest beats a
                // timeout landing on the same edge.
                if (!waitrequest) begin
                    state_d      = ST_IDLE;
                    read_d       = 1'b0;
                    write_d      = 1'b0;
                    byteenable_d = '0;
                    writedata_d  = '0;
                    resp_valid_d = 1'b1;
                    resp_err_d   = ERR_NONE;
                    resp_rdata_d = lat_write ? '0 : ld_result;
                end else if (TIMEOUT > 0 && cnt == CNT_LAST) begin
                    state_d      = ST_IDLE;
                    read_d       = 1'b0;
                    write_d      = 1'b0;
                    byteenable_d = '0;
                    writedata_d  = '0;
                    resp_valid_d = 1'b1;
                    resp_err_d   = ERR_TIMEOUT;
                    resp_rdata_d = '0;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            ST_ERR: begin
                state_d      = ST_IDLE;
                resp_valid_d = 1'b1;
                resp_err_d   = ERR_MISALIGN;
                resp_rdata_d = '0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            lat_write  <= 1'b0;
            lat_size   <= SZ_BYTE;
            lat_signed <= 1'b0;
            lat_lane   <= '0;
            cnt        <= '0;
            read       <= 1'b0;
            write      <= 1'b0;
            address    <= '0;
            writedata  <= '0;
            byteenable <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= ERR_NONE;
        end else begin
            state      <= state_d;
            lat_write  <= lat_write_d;
            lat_size   <= lat_size_d;
            lat_signed <= lat_signed_d;
            lat_lane   <= lat_lane_d;
            cnt        <= cnt_d;
            read       <= read_d;
            write      <= write_d;
            address    <= address_d;
            writedata  <= writedata_d;
            byteenable <= byteenable_d;
            resp_valid <= resp_valid_d;
            resp_rdata <= resp_rdata_d;
            resp_err   <= resp_err_d;
        end
    end

endmodule
